mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Unified instruction/data memory port for the multicycle RISC-V core. It sits directly downstream of the main control FSM and consumes that FSM's memory controls: MemRead, MemWrite, IorD and IRWrite. It performs word accesses to an internal memory array with a programmable number of wait states and latches the Instruction Register (IR) and Memory Data Register (MDR). It also splits IR into the decode fields used by the control FSM and by the ALU control.

## Interface
Parameters:
- DEPTH, 256: memory size in 32-bit words; must be a power of two.
- WAIT_CYCLES, 1: wait states per access, range 0–15.
- INIT_FILE, "": hex image loaded into the array at elaboration with readmemh; empty string means no preload.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  reset, synchronous, active-high.
- mem_read  in  1  read request; level, sampled only in IDLE.
- mem_write  in  1  write request; level, sampled only in IDLE.
- iord  in  1  address select: 0 = pc, 1 = alu_out.
- ir_write  in  1  on a read, also load the fetched word into IR.
- pc  in  32  instruction byte address.
- alu_out  in  32  data byte address.
- wdata  in  32  store data.
- mem_busy  out  1  high while an access is in flight (WAIT or DONE state).
- mem_done  out  1  one-cycle pulse in the DONE state.
- misalign  out  1  alignment fault pulse; see Configuration.
- ir  out  32  instruction register.
- mdr  out  32  memory data register.
- opcode  out  7  ir[6:0].
- rd  out  5  ir[11:7].
- funct3  out  3  ir[14:12].
- rs1  out  5  ir[19:15].
- rs2  out  5  ir[24:20].
- funct7  out  7  ir[31:25].

## Operation
State machine with three states:
- **IDLE**
  - If mem_write or mem_read is high, capture the following: address = (iord ? alu_out : pc), wdata, the request type, and ir_write.
  - If both mem_write and mem_read are high, the request is a write.
  - Next state: WAIT if WAIT_CYCLES > 0, otherwise DONE. The wait counter loads WAIT_CYCLES−1.
  - With no request, stay in IDLE.
- **WAIT**
  - Decrement the counter each cycle. Go to DONE when the counter is 0.
  - Inputs are ignored in this state.
- **DONE**
  - mem_done = 1.
  - On the edge that leaves DONE:
    - write: array[word] ← captured wdata.
    - read: mdr ← array[word]; if captured ir_write, also ir ← array[word].
  - Next state: IDLE.

Arithmetic and width rules:
- word index = captured address[log2(DEPTH)+1 : 2]. Upper bits are dropped, so addresses wrap modulo DEPTH×4.
- A write never modifies ir or mdr.
- A read with ir_write = 0 leaves ir unchanged.

Reset values:
- state = IDLE, ir = 0, mdr = 0, mem_busy = 0, mem_done = 0, misalign = 0.
- All decode fields are therefore 0 after reset.
- Array contents are not reset.

Reset mid-access:
- The access is aborted; no write is committed and ir/mdr are not loaded.
- State returns to IDLE on the next edge.

Requester protocol:
- The requester deasserts mem_read/mem_write in the cycle after it sees mem_done.
- A request still high in IDLE is accepted again as a new access.

## Timing
- Request sampled at edge k: mem_busy rises after edge k.
- mem_done is high in the cycle between edges k+W and k+W+1, where W = WAIT_CYCLES.
- ir/mdr/array are updated at edge k+W+1. Load-to-use latency is W+1 cycles.
- The next request can be accepted at edge k+W+2. Throughput is one access per W+2 cycles.
- Decode fields are combinational from ir and change in the same cycle as ir.
- mem_busy = (state != IDLE) and is registered-state derived, with no combinational path from the request inputs.

## Configuration
- MEM_ALIGN_CHECK_EN defined:
  - A captured address with bits [1:0] ≠ 0 produces misalign = 1 during DONE, in place of the access.
  - No write is committed; ir and mdr are unchanged.
  - mem_done still pulses.
- MEM_ALIGN_CHECK_EN undefined:
  - Address bits [1:0] are ignored.
  - misalign is tied to 0.

## Test plan
- Reset then idle: ir = 0, mdr = 0, opcode = 0, mem_busy = 0, mem_done = 0 for 5 cycles.
- WAIT_CYCLES=1, INIT word 0 = 0x00500093. Fetch with pc=0, iord=0, mem_read=1, ir_write=1: mem_done at cycle 2, ir = mdr = 0x00500093 from edge 2, opcode = 0x13, rd = 1, rs1 = 0.
- Store then load. Write with iord=1, alu_out=0x40, wdata=0xDEADBEEF. Then read alu_out=0x40 with ir_write=0: mdr = 0xDEADBEEF, ir unchanged.
- Simultaneous mem_read=1 and mem_write=1 to 0x44 with wdata=0x12345678: treated as a write; mdr unchanged; a later read of 0x44 returns 0x12345678.
- Reset asserted while in WAIT (WAIT_CYCLES=3) during a write of 0xFFFFFFFF to 0x48: no write committed, 0x48 keeps its old value, state is IDLE after one edge.
- MEM_ALIGN_CHECK_EN defined, read of alu_out=0x42: misalign = 1 and mem_done = 1 in the same cycle, mdr unchanged. With the macro undefined, the same read returns word 0x40.

Source files
------------

// File: rtl/mem_access_unit.sv
// Unified instruction/data memory port: word accesses with programmable wait states, IR/MDR latching and IR decode.
// Optional alignment fault checking is enabled by defining MEM_ALIGN_CHECK_EN.
module mem_access_unit #(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        iord,
  input  logic        ir_write,
  input  logic [31:0] pc,
  input  logic [31:0] alu_out,
  input  logic [31:0] wdata,
  output logic        mem_busy,
  output logic        mem_done,
  output logic        misalign,
  output logic [31:0] ir,
  output logic [31:0] mdr,
  output logic [6:0]  opcode,
  output logic [4:0]  rd,
  output logic [2:0]  funct3,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [6:0]  funct7
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [3:0]    r_cnt;
  logic [AW+1:0] r_addr;
  logic [31:0]   r_wdata;
  logic          r_is_write;
  logic          r_ir_write;
  logic [31:0]   r_ir;
  logic [31:0]   r_mdr;
  logic [31:0]   r_mem [DEPTH];

  logic [31:0]   w_addr;
  logic [AW-1:0] w_word;
  logic          w_req;
  logic          w_misalign;
  logic          w_commit;
  logic          w_unused;

  assign w_addr = iord ? alu_out : pc;
  assign w_req  = mem_read | mem_write;
  assign w_word = r_addr[AW+1:2];

`ifdef MEM_ALIGN_CHECK_EN
  assign w_misalign = (r_state == S_DONE) && (r_addr[1:0] != 2'b00);
  assign w_unused   = ^w_addr[31:AW+2];
`else
  assign w_misalign = 1'b0;
  assign w_unused   = ^{w_addr[31:AW+2], r_addr[1:0]};
`endif

  // A faulting access still passes through DONE but never touches array, IR or MDR.
  assign w_commit = (r_state == S_DONE) && !w_misalign;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (w_req) w_next_state = (WAIT_CYCLES > 0) ? S_WAIT : S_DONE;
      S_WAIT: if (r_cnt == 4'd0) w_next_state = S_DONE;
      S_DONE: w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ir    <= '0;
      r_mdr   <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_IDLE && w_req) begin
        r_cnt <= CNT_LOAD;
      end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_commit && !r_is_write) begin
        r_mdr <= r_mem[w_word];
        if (r_ir_write) r_ir <= r_mem[w_word];
      end
    end
  end

  // Request capture needs no reset: it is only consumed after a fresh acceptance.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && w_req) begin
      r_addr     <= w_addr[AW+1:0];
      r_wdata    <= wdata;
      r_is_write <= mem_write;
      r_ir_write <= ir_write;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_commit && r_is_write) r_mem[w_word] <= r_wdata;
  end

  assign mem_busy = (r_state != S_IDLE);
  assign mem_done = (r_state == S_DONE);
  assign misalign = w_misalign;
  assign ir       = r_ir;
  assign mdr      = r_mdr;
  assign opcode   = r_ir[6:0];
  assign rd       = r_ir[11:7];
  assign funct3   = r_ir[14:12];
  assign rs1      = r_ir[19:15];
  assign rs2      = r_ir[24:20];
  assign funct7   = r_ir[31:25];

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit: one instance with 1 wait state, one with 3.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset1 = 1'b1, reset3 = 1'b1;
    logic        mem_read = 1'b0, mem_write = 1'b0, iord = 1'b0, ir_write = 1'b0;
    logic [31:0] pc = '0, alu_out = '0, wdata = '0;

    logic        busy1, done1, mis1, busy3, done3, mis3;
    logic [31:0] ir1, mdr1, ir3, mdr3;
    logic [6:0]  op1, f7_1, op3, f7_3;
    logic [4:0]  rd1, rs1_1, rs2_1, rd3, rs1_3, rs2_3;
    logic [2:0]  f3_1, f3_3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.DEPTH(256), .WAIT_CYCLES(1), .INIT_FILE("")) dut1 (
        .clk(clk), .reset(reset1), .mem_read(mem_read), .mem_write(mem_write),
        .iord(iord), .ir_write(ir_write), .pc(pc), .alu_out(alu_out), .wdata(wdata),
        .mem_busy(busy1), .mem_done(done1), .misalign(mis1), .ir(ir1), .mdr(mdr1),
        .opcode(op1), .rd(rd1), .funct3(f3_1), .rs1(rs1_1), .rs2(rs2_1), .funct7(f7_1)
    );

    mem_access_unit #(.DEPTH(256), .WAIT_CYCLES(3), .INIT_FILE("")) dut3 (
        .clk(clk), .reset(reset3), .mem_read(mem_read), .mem_write(mem_write),
        .iord(iord), .ir_write(ir_write), .pc(pc), .alu_out(alu_out), .wdata(wdata),
        .mem_busy(busy3), .mem_done(done3), .misalign(mis3), .ir(ir3), .mdr(mdr3),
        .opcode(op3), .rd(rd3), .funct3(f3_3), .rs1(rs1_3), .rs2(rs2_3), .funct7(f7_3)
    );

    // Drive a request before edge k and drop it right after that edge.
    task automatic issue(input bit w, input bit r, input bit io, input bit irw, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        mem_write = w; mem_read = r; iord = io; ir_write = irw; wdata = d;
        if (io) begin alu_out = a; pc = ~a; end
        else    begin pc = a; alu_out = ~a; end
        @(posedge clk);
        #1;
        mem_write = 1'b0; mem_read = 1'b0;
    endtask

    // Returns the negedge index (1 = first after edge k) at which mem_done is seen, 0 on timeout.
    task automatic wait_done(input bit sel3, output int n);
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if ((sel3 ? done3 : done1) === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    // Full access: issue, wait for DONE, then step past the commit edge.
    task automatic access(input bit w, input bit r, input bit io, input bit irw, input logic [31:0] a,
                          input logic [31:0] d, input bit sel3, output int n);
        issue(w, r, io, irw, a, d);
        wait_done(sel3, n);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset1 = 1'b1; reset3 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset1 = 1'b0; reset3 = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++;
            if ({busy1, done1, mis1} !== 3'b000 || ir1 !== 32'h0 || mdr1 !== 32'h0 || op1 !== 7'h0) begin
                n_fail++;
                $display("FAIL reset_idle1 cyc=%0d busy=%b done=%b mis=%b ir=%h mdr=%h op=%h required 0", c, busy1, done1, mis1, ir1, mdr1, op1);
            end
            n_checks++;
            if ({busy3, done3, mis3} !== 3'b000 || ir3 !== 32'h0 || mdr3 !== 32'h0 || op3 !== 7'h0) begin
                n_fail++;
                $display("FAIL reset_idle3 cyc=%0d busy=%b done=%b mis=%b ir=%h mdr=%h op=%h required 0", c, busy3, done3, mis3, ir3, mdr3, op3);
            end
        end
    endtask

    task automatic test_fetch;
        int n;
        reset3 = 1'b1;
        access(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h00500093, 1'b0, n);
        n_checks++;
        if (n !== 2 || ir1 !== 32'h0 || mdr1 !== 32'h0) begin
            n_fail++;
            $display("FAIL store_word0 done_at=%0d ir=%h mdr=%h required done_at=2 ir=0 mdr=0", n, ir1, mdr1);
        end
        issue(1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0);
        @(negedge clk);
        n_checks++;
        if (busy1 !== 1'b1 || done1 !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_wait busy=%b done=%b required busy=1 done=0", busy1, done1);
        end
        @(negedge clk);
        n_checks++;
        if (busy1 !== 1'b1 || done1 !== 1'b1 || ir1 !== 32'h0) begin
            n_fail++;
            $display("FAIL fetch_done busy=%b done=%b ir=%h required busy=1 done=1 ir=0", busy1, done1, ir1);
        end
        @(negedge clk);
        n_checks++;
        if (busy1 !== 1'b0 || done1 !== 1'b0 || ir1 !== 32'h00500093 || mdr1 !== 32'h00500093) begin
            n_fail++;
            $display("FAIL fetch_load busy=%b done=%b ir=%h mdr=%h required 0 0 00500093 00500093", busy1, done1, ir1, mdr1);
        end
        n_checks++;
        if (op1 !== 7'h13 || rd1 !== 5'd1 || f3_1 !== 3'd0 || rs1_1 !== 5'd0 || rs2_1 !== 5'd5 || f7_1 !== 7'd0) begin
            n_fail++;
            $display("FAIL fetch_decode op=%h rd=%0d f3=%0d rs1=%0d rs2=%0d f7=%h required 13 1 0 0 5 0", op1, rd1, f3_1, rs1_1, rs2_1, f7_1);
        end
    endtask

    task automatic test_store_load;
        int n;
        access(1'b1, 1'b0, 1'b1, 1'b0, 32'h40, 32'hDEADBEEF, 1'b0, n);
        n_checks++;
        if (n !== 2 || mdr1 !== 32'h00500093 || ir1 !== 32'h00500093) begin
            n_fail++;
            $display("FAIL store40 done_at=%0d mdr=%h ir=%h required 2 00500093 00500093", n, mdr1, ir1);
        end
        access(1'b0, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, n);
        n_checks++;
        if (n !== 2 || mdr1 !== 32'hDEADBEEF || ir1 !== 32'h00500093) begin
            n_fail++;
            $display("FAIL load40 done_at=%0d mdr=%h ir=%h required 2 deadbeef 00500093", n, mdr1, ir1);
        end
    endtask

    task automatic test_rw_both;
        int n;
        access(1'b1, 1'b1, 1'b1, 1'b1, 32'h44, 32'h12345678, 1'b0, n);
        n_checks++;
        if (n !== 2 || mdr1 !== 32'hDEADBEEF || ir1 !== 32'h00500093) begin
            n_fail++;
            $display("FAIL both_is_write done_at=%0d mdr=%h ir=%h required 2 deadbeef 00500093", n, mdr1, ir1);
        end
        access(1'b0, 1'b1, 1'b1, 1'b0, 32'h440, 32'h0, 1'b0, n);
        n_checks++;
        if (mdr1 !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL addr_wrap mdr=%h required deadbeef", mdr1);
        end
        access(1'b0, 1'b1, 1'b1, 1'b0, 32'h44, 32'h0, 1'b0, n);
        n_checks++;
        if (mdr1 !== 32'h12345678) begin
            n_fail++;
            $display("FAIL load44 mdr=%h required 12345678", mdr1);
        end
    endtask

    task automatic test_misalign;
        int n;
        issue(1'b0, 1'b1, 1'b1, 1'b0, 32'h42, 32'h0);
        wait_done(1'b0, n);
`ifdef MEM_ALIGN_CHECK_EN
        n_checks++;
        if (n !== 2 || mis1 !== 1'b1) begin
            n_fail++;
            $display("FAIL misalign_pulse done_at=%0d misalign=%b required 2 1", n, mis1);
        end
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (mdr1 !== 32'h12345678 || mis1 !== 1'b0) begin
            n_fail++;
            $display("FAIL misalign_mdr mdr=%h misalign=%b required 12345678 0", mdr1, mis1);
        end
`else
        n_checks++;
        if (n !== 2 || mis1 !== 1'b0) begin
            n_fail++;
            $display("FAIL misalign_off done_at=%0d misalign=%b required 2 0", n, mis1);
        end
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (mdr1 !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL unaligned_read mdr=%h required deadbeef", mdr1);
        end
`endif
    endtask

    task automatic test_back_to_back;
        int dones = 0;
        @(negedge clk);
        mem_read = 1'b1; mem_write = 1'b0; iord = 1'b1; ir_write = 1'b0; alu_out = 32'h40;
        @(posedge clk);
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done1 === 1'b1) dones++;
        end
        mem_read = 1'b0;
        n_checks++;
        if (dones !== 2 || busy1 !== 1'b0 || mdr1 !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL back_to_back dones=%0d busy=%b mdr=%h required 2 0 deadbeef", dones, busy1, mdr1);
        end
        @(negedge clk);
        n_checks++;
        if (busy1 !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_release busy=%b required 0", busy1);
        end
    endtask

    task automatic test_reset_mid_access;
        int n;
        reset1 = 1'b1;
        @(negedge clk);
        reset3 = 1'b0;
        access(1'b1, 1'b0, 1'b1, 1'b0, 32'h48, 32'h0BADF00D, 1'b1, n);
        n_checks++;
        if (n !== 4) begin
            n_fail++;
            $display("FAIL wait3_latency done_at=%0d required 4", n);
        end
        issue(1'b1, 1'b0, 1'b1, 1'b0, 32'h48, 32'hFFFFFFFF);
        @(negedge clk);
        n_checks++;
        if (busy3 !== 1'b1 || done3 !== 1'b0) begin
            n_fail++;
            $display("FAIL wait3_busy busy=%b done=%b required 1 0", busy3, done3);
        end
        reset3 = 1'b1;
        @(posedge clk);
        #1;
        reset3 = 1'b0;
        n_checks++;
        if (busy3 !== 1'b0 || done3 !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle busy=%b done=%b required 0 0", busy3, done3);
        end
        repeat (4) @(negedge clk);
        access(1'b0, 1'b1, 1'b1, 1'b1, 32'h48, 32'h0, 1'b1, n);
        n_checks++;
        if (mdr3 !== 32'h0BADF00D || ir3 !== 32'h0BADF00D) begin
            n_fail++;
            $display("FAIL abort_no_write mdr=%h ir=%h required 0badf00d 0badf00d", mdr3, ir3);
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store_load();
        test_rw_both();
        test_misalign();
        test_back_to_back();
        test_reset_mid_access();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout sim time exceeded required completion");
        $fatal(1);
    end

endmodule
